// File: rtl/d_hazard_scoreboard_pkg.sv
// Shared constants for the decode-stage hazard unit: field widths, stage
// index encoding for forward selects, and default MDU latencies.
package d_hazard_scoreboard_pkg;

  localparam int TW_DEF       = 2;
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  localparam int STG_RF = 0;
  localparam int STG_E  = 1;
  localparam int STG_M  = 2;
  localparam int STG_W  = 3;

endpackage

// File: rtl/d_hazard_scoreboard_mdu_busy_model.sv
// Busy model for the multiply/divide unit: a countdown started by a
// mult/div in E that stalls any HI/LO instruction sitting in D.
module d_hazard_scoreboard_mdu_busy_model
  import d_hazard_scoreboard_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  input  logic hilo_op,
  output logic busy,
  output logic stall_mdu
);

  localparam int CW = $clog2(DIV_CYC + 1);

  logic [CW-1:0] cnt;

  // A start while still counting reloads: the newest operation owns HI/LO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy      = start | (cnt != '0);
  assign stall_mdu = hilo_op & busy;

endmodule

// File: rtl/d_hazard_scoreboard.sv
// Decode-stage hazard unit: Tnew-countdown scoreboard of in-flight writers,
// Tuse comparison for stall, youngest-match forward select, stall counter.
module d_hazard_scoreboard
  import d_hazard_scoreboard_pkg::*;
#(
  parameter int NSTAGE   = 3,
  parameter int TW       = TW_DEF,
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNTW     = 32,
  localparam int FW      = $clog2(NSTAGE + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      D_rs,
  input  logic [4:0]      D_rt,
  input  logic [TW-1:0]   D_Tuse_rs,
  input  logic [TW-1:0]   D_Tuse_rt,
  input  logic [4:0]      D_A3,
  input  logic [TW-1:0]   D_Tnew,
  input  logic            D_HILO_op,
  input  logic            E_mdu_start,
  input  logic            E_mdu_div,
  output logic            stall,
  output logic [FW-1:0]   fwd_rs,
  output logic [FW-1:0]   fwd_rt,
  output logic            mdu_busy,
  output logic [CNTW-1:0] stall_cnt
);

  logic [4:0]    a3_q   [1:NSTAGE];
  logic [TW-1:0] tnew_q [1:NSTAGE];
  logic [NSTAGE:1] hit_rs, hit_rt, haz_rs, haz_rt;
  logic stall_mdu;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? t : t - TW'(1);
  endfunction

  // Stalled cycles still drain the older stages; only stage 1 takes a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        a3_q[k]   <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      a3_q[1]   <= stall ? '0 : D_A3;
      tnew_q[1] <= stall ? '0 : D_Tnew;
      for (int k = 2; k <= NSTAGE; k++) begin
        a3_q[k]   <= a3_q[k-1];
        tnew_q[k] <= sat_dec(tnew_q[k-1]);
      end
    end
  end

  // A nonzero source match implies a nonzero writer, so $0 never hits.
  for (genvar k = 1; k <= NSTAGE; k++) begin : g_cmp
    assign hit_rs[k] = (D_rs != '0) && (a3_q[k] == D_rs);
    assign hit_rt[k] = (D_rt != '0) && (a3_q[k] == D_rt);
    assign haz_rs[k] = hit_rs[k] && (tnew_q[k] > D_Tuse_rs);
    assign haz_rt[k] = hit_rt[k] && (tnew_q[k] > D_Tuse_rt);
  end

  // Scan oldest to youngest so the youngest match is the last write.
  always_comb begin
    fwd_rs = FW'(STG_RF);
    fwd_rt = FW'(STG_RF);
    for (int k = NSTAGE; k >= 1; k--) begin
      if (hit_rs[k]) fwd_rs = FW'(k);
      if (hit_rt[k]) fwd_rt = FW'(k);
    end
  end

  d_hazard_scoreboard_mdu_busy_model #(
    .MULT_CYC(MULT_CYC),
    .DIV_CYC (DIV_CYC)
  ) u_mdu_busy_model (
    .clk      (clk),
    .reset    (reset),
    .start    (E_mdu_start),
    .div      (E_mdu_div),
    .hilo_op  (D_HILO_op),
    .busy     (mdu_busy),
    .stall_mdu(stall_mdu)
  );

  assign stall = (|haz_rs) | (|haz_rt) | stall_mdu;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule
